// File: rtl/bt_pkg.sv
// bt_pkg: shared ALU codes, direction-counter type, BTB entry and helpers; BTB_HYST_EN selects 2-bit counters.
package bt_pkg;
  localparam logic [3:0] AluCtrlBeq  = 4'h8;
  localparam logic [3:0] AluCtrlBne  = 4'h9;
  localparam logic [3:0] AluCtrlBeqz = 4'hA;
  localparam logic [3:0] AluCtrlBnez = 4'hB;
  localparam logic [3:0] AluCtrlJump = 4'hC;
  localparam int BtMaxW = 64;
`ifdef BTB_HYST_EN
  typedef logic [1:0] ctr_t;
  localparam ctr_t SNT = 2'b00;
  localparam ctr_t WNT = 2'b01;
  localparam ctr_t WT  = 2'b10;
  localparam ctr_t ST  = 2'b11;
`else
  typedef logic [0:0] ctr_t;
  localparam ctr_t SNT = 1'b0;
  localparam ctr_t WNT = 1'b0;
  localparam ctr_t WT  = 1'b1;
  localparam ctr_t ST  = 1'b1;
`endif
  // Tag and target fields are sized for the widest supported XLEN.
  typedef struct packed {
    logic              valid;
    logic [BtMaxW-1:0] tag;
    logic [BtMaxW-1:0] target;
    ctr_t              ctr;
  } btb_entry_t;
  function automatic logic [BtMaxW-1:0] sext(input logic [22:0] f, input int msb);
    logic [BtMaxW-1:0] m;
    m = (64'd1 << (msb + 1)) - 64'd1;
    return f[msb] ? ({41'd0, f} | ~m) : ({41'd0, f} & m);
  endfunction
  function automatic ctr_t ctr_inc(input ctr_t c);
    return c == ST ? ST : ctr_t'(c + 1'b1);
  endfunction
  function automatic ctr_t ctr_dec(input ctr_t c);
    return c == SNT ? SNT : ctr_t'(c - 1'b1);
  endfunction
endpackage

// File: rtl/bt_target_calc.sv
// bt_target_calc: decodes branch ops and computes the pc-relative target.
module bt_target_calc
  import bt_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      alu_control,
  input  logic [23:0]     instruction,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] target,
  output logic            is_br,
  output logic            is_jump
);
  logic is_z;
  logic [BtMaxW-1:0] off;
  always_comb begin
    is_jump = alu_control == AluCtrlJump;
    is_z = alu_control inside {AluCtrlBeqz, AluCtrlBnez};
    is_br = is_jump || is_z || alu_control inside {AluCtrlBeq, AluCtrlBne};
    off = is_jump ? sext(instruction[23:1], 22) : is_z ? sext({8'd0, instruction[15:1]}, 14) : sext({10'd0, instruction[13:1]}, 12);
    target = pc + off[XLEN-1:0];
  end
endmodule

// File: rtl/branch_target_btb.sv
// branch_target_btb: registered branch target, mispredict flag and direct-mapped BTB with direction counters.
// Optional 2-bit hysteresis counters under BTB_HYST_EN.
module branch_target_btb
  import bt_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            res_valid,
  input  logic [3:0]      alu_control,
  input  logic [23:0]     instruction,
  input  logic [XLEN-1:0] pc,
  input  logic            res_taken,
  input  logic            res_pred_taken,
  input  logic [XLEN-1:0] res_pred_target,
  input  logic            fetch_req,
  input  logic [XLEN-1:0] fetch_pc,
  input  logic            flush,
  input  logic            btb_clear,
  output logic [XLEN-1:0] branch_addr,
  output logic            mispredict,
  output logic            pred_valid,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target
);
  logic [XLEN-1:0] tgt;
  logic is_br, is_jump, upd, taken, r_hit, f_hit, f_v;
  logic [IDX_W-1:0] ridx, fidx;
  btb_entry_t btb [ENTRIES];
  bt_target_calc #(.XLEN(XLEN)) u_calc (
    .alu_control(alu_control),
    .instruction(instruction),
    .pc(pc),
    .target(tgt),
    .is_br(is_br),
    .is_jump(is_jump)
  );
  always_comb begin
    upd = res_valid && is_br;
    taken = res_taken || is_jump;
    ridx = pc[IDX_W:1];
    fidx = fetch_pc[IDX_W:1];
    r_hit = btb[ridx].valid && btb[ridx].tag == BtMaxW'(pc[XLEN-1:IDX_W+1]);
    f_hit = btb[fidx].valid && btb[fidx].tag == BtMaxW'(fetch_pc[XLEN-1:IDX_W+1]);
    f_v = fetch_req && !flush;
  end
  // Clear beats update; lookups read the array before this edge's write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) btb[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
    end else if (btb_clear) begin
      for (int i = 0; i < ENTRIES; i++) btb[i].valid <= 1'b0;
    end else if (upd && taken) begin
      btb[ridx].valid <= 1'b1;
      btb[ridx].tag <= BtMaxW'(pc[XLEN-1:IDX_W+1]);
      btb[ridx].target <= BtMaxW'(tgt);
      btb[ridx].ctr <= r_hit ? ctr_inc(btb[ridx].ctr) : WT;
    end else if (upd && r_hit) begin
      btb[ridx].ctr <= ctr_dec(btb[ridx].ctr);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_addr <= '0;
      mispredict <= 1'b0;
      pred_valid <= 1'b0;
      pred_hit <= 1'b0;
      pred_taken <= 1'b0;
      pred_target <= '0;
    end else begin
      branch_addr <= upd ? tgt : branch_addr;
      mispredict <= upd && (taken != res_pred_taken || (taken && tgt != res_pred_target));
      pred_valid <= f_v;
      pred_hit <= f_v && f_hit;
      pred_taken <= f_v && f_hit && btb[fidx].ctr[$bits(ctr_t)-1];
      pred_target <= (f_v && f_hit) ? btb[fidx].target[XLEN-1:0] : '0;
    end
  end
endmodule
